// File: rtl/scancode_decoder_if.sv
// Byte-stream input and key-event output bundle of the PS/2 scancode decoder.
interface scancode_decoder_if;
   logic [7:0] CODEWORD;
   logic       scan_err;
   logic       rd_en;
   logic       evt_valid;
   logic [7:0] evt_code;
   logic       evt_ext;
   logic       evt_release;
   logic       evt_is_digit;
   logic [3:0] evt_digit;
   logic       fifo_full;
   logic       overflow;
   logic       err_seen;

   modport master (
      output CODEWORD, scan_err, rd_en,
      input  evt_valid, evt_code, evt_ext, evt_release, evt_is_digit, evt_digit,
             fifo_full, overflow, err_seen
   );

   modport slave (
      input  CODEWORD, scan_err, rd_en,
      output evt_valid, evt_code, evt_ext, evt_release, evt_is_digit, evt_digit,
             fifo_full, overflow, err_seen
   );
endinterface

// File: rtl/scancode_decoder.sv
// PS/2 set-2 scancode decoder: E0/F0 prefix FSM with timeout, numpad digit map,
// and a show-ahead key-event FIFO with registered head outputs.
module scancode_decoder #(
   parameter int unsigned TIMEOUT_CYCLES = 2000000,
   parameter int unsigned FIFO_DEPTH     = 4
) (
   input logic               CLK,
   input logic               RST_N,
   scancode_decoder_if.slave bus
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [7:0] CODE_EXT = 8'hE0;
   localparam logic [7:0] CODE_BRK = 8'hF0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK
   } state_t;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
      logic       is_digit;
      logic [3:0] digit;
   } evt_t;

   state_t           state_q, state_n;
   logic [TMO_W-1:0] tmo_q, tmo_n;
   logic             scan_err_q;
   logic             err_seen_q;
   logic             overflow_q;
   logic             err_rise;
   logic             strobe;
   logic             push;
   evt_t             new_evt;

   evt_t             mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   evt_t             head_q, head_n;
   logic             valid_q;
   logic             full_q;
   logic             pop;
   logic             push_ok;
   logic             drop;

   // {is_digit, digit} for a non-extended base code
   function automatic logic [4:0] digit_map(input logic [7:0] c);
      logic [4:0] r;
      case (c)
         8'h70:   r = {1'b1, 4'd0};
         8'h69:   r = {1'b1, 4'd1};
         8'h72:   r = {1'b1, 4'd2};
         8'h7A:   r = {1'b1, 4'd3};
         8'h6B:   r = {1'b1, 4'd4};
         8'h73:   r = {1'b1, 4'd5};
         8'h74:   r = {1'b1, 4'd6};
         8'h6C:   r = {1'b1, 4'd7};
         8'h75:   r = {1'b1, 4'd8};
         8'h7D:   r = {1'b1, 4'd9};
         8'h71:   r = {1'b1, 4'd10};
         8'h7B:   r = {1'b1, 4'd15};
         default: r = 5'd0;
      endcase
      return r;
   endfunction

   assign strobe   = |bus.CODEWORD;
   assign err_rise = bus.scan_err & ~scan_err_q;

   // Prefix FSM next state, timeout counter and event assembly
   always_comb begin
      state_n = state_q;
      tmo_n   = '0;
      push    = 1'b0;
      new_evt = '0;
      if (err_rise) begin
         state_n = ST_IDLE;
      end else if (strobe) begin
         if (bus.CODEWORD == CODE_EXT) begin
            state_n = ST_EXT;
         end else if (bus.CODEWORD == CODE_BRK) begin
            if (state_q == ST_IDLE)     state_n = ST_BRK;
            else if (state_q == ST_EXT) state_n = ST_EXT_BRK;
         end else begin
            push         = 1'b1;
            new_evt.code = bus.CODEWORD;
            new_evt.ext  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
            new_evt.brk  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
            if (!new_evt.ext) {new_evt.is_digit, new_evt.digit} = digit_map(bus.CODEWORD);
            state_n      = ST_IDLE;
         end
      end else if (state_q != ST_IDLE) begin
         if (tmo_q == TMO_LAST) state_n = ST_IDLE;
         else                   tmo_n   = tmo_q + TMO_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= ST_IDLE;
         tmo_q      <= '0;
         scan_err_q <= 1'b0;
         err_seen_q <= 1'b0;
      end else begin
         state_q    <= state_n;
         tmo_q      <= tmo_n;
         scan_err_q <= bus.scan_err;
         if (err_rise) err_seen_q <= 1'b1;
      end
   end

   // FIFO bookkeeping; the head register is loaded with whatever entry will be at the head next cycle
   always_comb begin
      pop      = bus.rd_en & valid_q;
      push_ok  = push & (~full_q | pop);
      drop     = push & full_q & ~pop;
      cnt_n    = cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
      rd_ptr_n = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      head_n   = '0;
      if (cnt_n != '0) begin
         if (push_ok && ((cnt_q - CNT_W'(pop)) == '0)) head_n = new_evt;
         else                                          head_n = mem_q[rd_ptr_n];
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         head_q     <= '0;
         valid_q    <= 1'b0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= new_evt;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         rd_ptr_q <= rd_ptr_n;
         cnt_q    <= cnt_n;
         head_q   <= head_n;
         valid_q  <= (cnt_n != '0);
         full_q   <= (cnt_n == CNT_FULL);
         if (drop) overflow_q <= 1'b1;
      end
   end

   assign bus.evt_valid    = valid_q;
   assign bus.evt_code     = head_q.code;
   assign bus.evt_ext      = head_q.ext;
   assign bus.evt_release  = head_q.brk;
   assign bus.evt_is_digit = head_q.is_digit;
   assign bus.evt_digit    = head_q.digit;
   assign bus.fifo_full    = full_q;
   assign bus.overflow     = overflow_q;
   assign bus.err_seen     = err_seen_q;

endmodule
